// File: rtl/alu_sweep_ctrl_if.sv
// Result stream between the sweep engine and its consumer.
// master: the sweep engine (drives res_valid/res_opcode/res_y/res_flags,
//         samples res_ready).
// slave:  the consumer (samples the result, drives res_ready).
// res_flags packing is {invalid_op, parity, zero, borrow_out, carry_out}.
interface alu_sweep_ctrl_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 res_valid;
  logic                 res_ready;
  logic [3:0]           res_opcode;
  logic [BUS_WIDTH-1:0] res_y;
  logic [4:0]           res_flags;

  modport master (
    output res_valid, res_opcode, res_y, res_flags,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_opcode, res_y, res_flags,
    output res_ready
  );
endinterface

// File: rtl/alu_sweep_ctrl.sv
// Stimulus/capture engine for the combinational alu block.
// On an accepted start it latches one operand pair plus carry/borrow
// config, steps the ALU through opcodes 0..NUM_OPS-1, registers every
// result with its flags, and offers each one on a valid/ready stream.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a sweep (only honoured in IDLE)
//   a_in, b_in        operands, latched on accepted start
//   carry_in_cfg,
//   borrow_in_cfg     carry/borrow inputs, latched on accepted start
//   alu_a, alu_b,
//   alu_carry_in,
//   alu_borrow_in     latched stimulus held for the whole sweep
//   alu_opcode        opcode currently driven to the ALU
//   alu_y, alu_*      ALU result and flags
//   res               result stream (master side)
//   busy              high while driving/presenting (DRIVE, OUT)
//   done              one-cycle pulse at the end of a sweep
//   invalid_count     captures with invalid_op set in current/last sweep
module alu_sweep_ctrl #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_OPS   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] a_in,
  input  logic [BUS_WIDTH-1:0] b_in,
  input  logic                 carry_in_cfg,
  input  logic                 borrow_in_cfg,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic                 alu_carry_in,
  output logic                 alu_borrow_in,
  output logic [3:0]           alu_opcode,
  input  logic [BUS_WIDTH-1:0] alu_y,
  input  logic                 alu_carry_out,
  input  logic                 alu_borrow_out,
  input  logic                 alu_zero,
  input  logic                 alu_parity,
  input  logic                 alu_invalid_op,
  alu_sweep_ctrl_if.master     res,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           invalid_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_OP = 4'(NUM_OPS - 1);

  state_t state, state_nxt;
  logic   accept_start;
  logic   capture;
  logic   handshake;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept_start  = 1'b0;
    capture       = 1'b0;
    handshake     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    res.res_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = DRIVE;
        end
      end
      DRIVE: begin
        // The ALU is combinational: its outputs for alu_opcode are
        // settled by the end of this cycle, so capture on the way out.
        busy      = 1'b1;
        capture   = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        busy          = 1'b1;
        res.res_valid = 1'b1;
        if (res.res_ready) begin
          handshake = 1'b1;
          state_nxt = (alu_opcode == LAST_OP) ? DONE : DRIVE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stimulus and capture registers. Everything is cleared by reset because
  // all outputs must read zero while rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a          <= '0;
      alu_b          <= '0;
      alu_carry_in   <= 1'b0;
      alu_borrow_in  <= 1'b0;
      alu_opcode     <= '0;
      res.res_opcode <= '0;
      res.res_y      <= '0;
      res.res_flags  <= '0;
      invalid_count  <= '0;
    end else begin
      if (accept_start) begin
        alu_a         <= a_in;
        alu_b         <= b_in;
        alu_carry_in  <= carry_in_cfg;
        alu_borrow_in <= borrow_in_cfg;
        alu_opcode    <= '0;
        invalid_count <= '0;
      end
      if (capture) begin
        res.res_opcode <= alu_opcode;
        res.res_y      <= alu_y;
        res.res_flags  <= {alu_invalid_op, alu_parity, alu_zero,
                           alu_borrow_out, alu_carry_out};
        invalid_count  <= invalid_count + {4'd0, alu_invalid_op};
      end
      // The opcode is left at the last value after the final handshake so
      // it still identifies the last op driven until the next start.
      if (handshake && (alu_opcode != LAST_OP)) begin
        alu_opcode <= alu_opcode + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Self-checking bench for alu_sweep_ctrl with a behavioural ALU attached.
module tb_alu_sweep_ctrl;
  localparam int BW   = 8;
  localparam int NOPS = 16;

  typedef struct packed {
    logic [7:0] y;
    logic [4:0] flags;  // {invalid, parity, zero, borrow, carry}
  } alu_res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       bi;
    int         op;
    logic [7:0] exp_y;
    logic [4:0] exp_flags;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in, b_in;
  logic       carry_in_cfg, borrow_in_cfg;
  logic [7:0] alu_a, alu_b;
  logic       alu_carry_in, alu_borrow_in;
  logic [3:0] alu_opcode;
  logic [7:0] alu_y;
  logic       alu_carry_out, alu_borrow_out, alu_zero, alu_parity, alu_invalid_op;
  logic       busy, done;
  logic [4:0] invalid_count;
  alu_res_t   alu_now;

  alu_sweep_ctrl_if #(.BUS_WIDTH(BW)) res_if ();

  int         tests = 0;
  int         fails = 0;
  logic [7:0] got_y  [NOPS];
  logic [4:0] got_fl [NOPS];
  vec_t       vecs   [8];

  always #5 clk = ~clk;

  alu_sweep_ctrl #(.BUS_WIDTH(BW), .NUM_OPS(NOPS)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .a_in           (a_in),
    .b_in           (b_in),
    .carry_in_cfg   (carry_in_cfg),
    .borrow_in_cfg  (borrow_in_cfg),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_carry_in   (alu_carry_in),
    .alu_borrow_in  (alu_borrow_in),
    .alu_opcode     (alu_opcode),
    .alu_y          (alu_y),
    .alu_carry_out  (alu_carry_out),
    .alu_borrow_out (alu_borrow_out),
    .alu_zero       (alu_zero),
    .alu_parity     (alu_parity),
    .alu_invalid_op (alu_invalid_op),
    .res            (res_if.master),
    .busy           (busy),
    .done           (done),
    .invalid_count  (invalid_count)
  );

  // Behavioural ALU: opcodes 14 and 15 are undefined and flag invalid_op.
  function automatic alu_res_t alu_ref(input logic [7:0] a, input logic [7:0] b,
                                       input logic ci, input logic bi,
                                       input logic [3:0] op);
    alu_res_t   r;
    logic [8:0] w;
    logic       co, bo, inv;
    w = '0; co = 1'b0; bo = 1'b0; inv = 1'b0; r.y = '0;
    case (op)
      4'd0:  begin w = {1'b0, a} + {1'b0, b} + 9'(ci); r.y = w[7:0]; co = w[8]; end
      4'd1:  begin w = {1'b0, a} - {1'b0, b} - 9'(bi); r.y = w[7:0]; bo = w[8]; end
      4'd2:  r.y = a & b;
      4'd3:  r.y = a | b;
      4'd4:  r.y = a ^ b;
      4'd5:  r.y = ~a;
      4'd6:  r.y = a << 1;
      4'd7:  r.y = a >> 1;
      4'd8:  r.y = b;
      4'd9:  r.y = a + 8'd1;
      4'd10: r.y = a - 8'd1;
      4'd11: r.y = ~(a & b);
      4'd12: r.y = ~(a | b);
      4'd13: r.y = {a[3:0], a[7:4]};
      default: inv = 1'b1;
    endcase
    r.flags = {inv, ^r.y, (r.y == 8'd0), bo, co};
    return r;
  endfunction

  always_comb begin
    alu_now        = alu_ref(alu_a, alu_b, alu_carry_in, alu_borrow_in, alu_opcode);
    alu_y          = alu_now.y;
    alu_carry_out  = alu_now.flags[0];
    alu_borrow_out = alu_now.flags[1];
    alu_zero       = alu_now.flags[2];
    alu_parity     = alu_now.flags[3];
    alu_invalid_op = alu_now.flags[4];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {alu_a, alu_b, alu_carry_in, alu_borrow_in, alu_opcode,
                 res_if.res_valid, res_if.res_opcode, res_if.res_y, res_if.res_flags,
                 busy, done, invalid_count}, 64'd0);
  endtask

  // One sweep against the expected timeline: start is sampled at E0, each
  // opcode spends one cycle being driven then is presented until accepted,
  // and done follows the acceptance of the last opcode.
  task automatic run_sweep(input logic [7:0] a, input logic [7:0] b,
                           input logic ci, input logic bi,
                           input int ready_pct, input int stall_op, input int stall_len,
                           input int busy_start_cyc, input int rst_op, input bit done_start,
                           output int done_cyc);
    int       exp_op, stalls, stall_left, exp_inv, dk;
    bit       exp_valid, rdy;
    alu_res_t e;
    exp_op = 0; stalls = 0; stall_left = stall_len; exp_inv = 0;
    exp_valid = 1'b0; done_cyc = -1;
    @(negedge clk);
    a_in = a; b_in = b; carry_in_cfg = ci; borrow_in_cfg = bi;
    start = 1'b1; res_if.res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      a_in  = a;
      start = 1'b0;
      check("hold_operands", {alu_a, alu_b, alu_carry_in, alu_borrow_in}, {a, b, ci, bi});
      if (exp_op == NOPS) begin
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("valid_at_done", res_if.res_valid, 0);
        done_cyc = cyc;
        break;
      end
      check("done_low", done, 0);
      check("busy", busy, 1);
      check("res_valid", res_if.res_valid, exp_valid);
      check("alu_opcode", alu_opcode, exp_op);
      if (exp_valid) begin
        if (exp_op == rst_op) begin
          rst = 1'b1;
          #1;
          check_all_zero("reset_mid_sweep");
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        e = alu_ref(a, b, ci, bi, 4'(exp_op));
        check("res_opcode", res_if.res_opcode, exp_op);
        check("res_y", res_if.res_y, e.y);
        check("res_flags", res_if.res_flags, e.flags);
        if (exp_op == stall_op && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else if (ready_pct < 100) begin
          rdy = ($urandom_range(0, 99) < ready_pct);
        end else begin
          rdy = 1'b1;
        end
        res_if.res_ready = rdy;
        if (rdy) begin
          got_y[exp_op]  = res_if.res_y;
          got_fl[exp_op] = res_if.res_flags;
          exp_inv += int'(e.flags[4]);
          exp_op++;
          exp_valid = 1'b0;
        end else begin
          stalls++;
        end
      end else begin
        res_if.res_ready = ($urandom_range(0, 1) == 1);
        exp_valid = 1'b1;
      end
      if (cyc == busy_start_cyc) begin
        a_in  = 8'h11;
        start = 1'b1;
      end
      @(negedge clk);
    end
    check("sweep_finished", (done_cyc > 0), 1);
    if (done_cyc > 0) begin
      check("done_cycle", done_cyc, 2 * NOPS + 1 + stalls);
      check("invalid_count", invalid_count, exp_inv);
      if (done_start) start = 1'b1;
      @(negedge clk);
      check("idle_after_done", {busy, done, res_if.res_valid}, 3'b000);
      check("opcode_holds", alu_opcode, NOPS - 1);
      check("res_kept", res_if.res_opcode, NOPS - 1);
      check("invalid_count_kept", invalid_count, exp_inv);
      if (done_start) begin
        // start stayed high into the first IDLE cycle and is taken there
        @(negedge clk);
        start = 1'b0;
        res_if.res_ready = 1'b1;
        check("start_in_idle_accepted", busy, 1);
        check("restart_opcode", alu_opcode, 0);
        check("restart_count_cleared", invalid_count, 0);
        dk = -1;
        for (int k = 2; k < 300; k++) begin
          @(negedge clk);
          if (done) begin
            dk = k;
            break;
          end
        end
        check("restart_done_cycle", dk, 2 * NOPS + 1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    carry_in_cfg = 1'b0; borrow_in_cfg = 1'b0; res_if.res_ready = 1'b0;

    vecs[0] = '{8'd25,  8'd25,  1'b0, 1'b0, 1,  8'h00, 5'b00100};
    vecs[1] = '{8'h8F,  8'h03,  1'b0, 1'b0, 0,  8'h92, 5'b01000};
    vecs[2] = '{8'hFF,  8'h01,  1'b0, 1'b0, 0,  8'h00, 5'b00101};
    vecs[3] = '{8'h00,  8'h01,  1'b0, 1'b0, 1,  8'hFF, 5'b00010};
    vecs[4] = '{8'hF0,  8'h0F,  1'b0, 1'b0, 2,  8'h00, 5'b00100};
    vecs[5] = '{8'h8F,  8'h03,  1'b0, 1'b0, 14, 8'h00, 5'b10100};
    vecs[6] = '{8'h10,  8'h20,  1'b1, 1'b0, 0,  8'h31, 5'b01000};
    vecs[7] = '{8'h05,  8'h03,  1'b0, 1'b1, 1,  8'h01, 5'b01000};

    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // full-throughput sweep
    run_sweep(8'h8F, 8'h03, 1'b0, 1'b0, 100, -1, 0, -1, -1, 1'b0, dc);
    check("full_sweep_done_cycle", dc, 33);
    check("invalid_flag_op13", got_fl[13][4], 0);
    check("invalid_flag_op14", got_fl[14][4], 1);
    check("invalid_flag_op15", got_fl[15][4], 1);
    check("invalid_count_two", invalid_count, 2);

    // five cycles of backpressure on opcode 3
    run_sweep(8'h8F, 8'h03, 1'b0, 1'b0, 100, 3, 5, -1, -1, 1'b0, dc);
    check("backpressure_done_cycle", dc, 38);

    // start pulse with a different operand while busy
    run_sweep(8'h8F, 8'h03, 1'b0, 1'b0, 100, -1, 0, 10, -1, 1'b0, dc);
    check("start_while_busy_done_cycle", dc, 33);

    // reset during OUT of opcode 7, then a clean restart
    run_sweep(8'h8F, 8'h03, 1'b0, 1'b0, 100, -1, 0, -1, 7, 1'b0, dc);
    check("no_done_after_reset", done, 0);
    run_sweep(8'd25, 8'd25, 1'b0, 1'b0, 100, -1, 0, -1, -1, 1'b0, dc);
    check("zero_sub_y", got_y[1], 8'h00);
    check("zero_sub_flag", got_fl[1][2], 1);

    // start coinciding with done is dropped, the next IDLE start is taken
    run_sweep(8'h3C, 8'hA5, 1'b1, 1'b1, 100, -1, 0, -1, -1, 1'b1, dc);

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      run_sweep(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].bi, 100, -1, 0, -1, -1, 1'b0, dc);
      check($sformatf("vec%0d_y", i), got_y[vecs[i].op], vecs[i].exp_y);
      check($sformatf("vec%0d_flags", i), got_fl[vecs[i].op], vecs[i].exp_flags);
    end

    // randomized operands and consumer stalls
    for (int i = 0; i < 6; i++) begin
      run_sweep(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                60, int'($urandom_range(0, NOPS - 1)), int'($urandom_range(0, 3)),
                -1, -1, 1'b0, dc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sweep_ctrl.md
# alu_sweep_ctrl

Sequential stimulus/capture engine for the `alu` block. On a start pulse it latches one operand pair, steps the ALU through every opcode from 0 to NUM_OPS-1, and registers each ALU result and flag set. Each result is presented on a valid/ready output stream. It sits between a host/debug controller and the combinational `alu`, and gives on-chip self-test and characterisation of the ALU.

## Interface
- BUS_WIDTH, 8, operand/result width; must match the attached `alu`.
- NUM_OPS, 16, number of opcodes swept (1..16); the opcode field is 4 bits.
- Reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- a_in, b_in  in  BUS_WIDTH  operands; latched on an accepted start.
- carry_in_cfg, borrow_in_cfg  in  1  carry/borrow inputs; latched on an accepted start.
- alu_a, alu_b  out  BUS_WIDTH  latched operands driven to the ALU.
- alu_carry_in, alu_borrow_in  out  1  latched carry/borrow driven to the ALU.
- alu_opcode  out  4  current opcode.
- alu_y  in  BUS_WIDTH  ALU result.
- alu_carry_out, alu_borrow_out, alu_zero, alu_parity, alu_invalid_op  in  1  ALU flags.
- res_valid  out  1  a captured result is available.
- res_ready  in  1  consumer accepts the result.
- res_opcode  out  4  opcode of the captured result.
- res_y  out  BUS_WIDTH  captured result.
- res_flags  out  5  {invalid_op, parity, zero, borrow_out, carry_out} (bit 4 down to bit 0).
- busy  out  1  high in DRIVE and OUT.
- done  out  1  one-cycle pulse at sweep end.
- invalid_count  out  5  number of captures with invalid_op=1 in the current or last sweep.

## Operation
- FSM states and transitions:
  - IDLE -> DRIVE on start=1. Latch the operands and cfg bits, set opcode=0, clear invalid_count.
  - DRIVE -> OUT always after one cycle. On the leaving edge, capture alu_y, the flags and the current opcode into the res_* registers; invalid_count += alu_invalid_op.
  - OUT -> DRIVE on res_valid && res_ready when opcode < NUM_OPS-1; opcode increments on the same edge.
  - OUT -> DONE on the accepted handshake when opcode == NUM_OPS-1.
  - DONE -> IDLE always after one cycle.
- Output hold rules:
  - alu_a, alu_b, alu_carry_in and alu_borrow_in are held constant for the whole sweep.
  - alu_opcode changes only on an accepted handshake.
  - alu_opcode is not reset to 0 by DONE; it holds the last value until the next start.
- res_valid is high only in OUT. While res_ready is low, res_* hold stable.
- start is ignored in DRIVE, OUT and DONE; no queuing.
- res_* keep the last captured values after a sweep ends.
- invalid_count cannot exceed 16, so 5 bits never overflow.

## Timing
- Reset (asynchronous, any state): the FSM goes to IDLE immediately. All outputs are 0: alu_a, alu_b, alu_carry_in, alu_borrow_in, alu_opcode, res_valid, res_opcode, res_y, res_flags, busy, done and invalid_count. Any in-flight sweep is abandoned without a done pulse.
- Sweep timeline: start sampled at edge E0. DRIVE occupies cycle 1 and res_valid rises in cycle 2.
- With res_ready tied high, opcode k is driven in cycle 2k+1 and presented in cycle 2k+2.
- For NUM_OPS=16: the last result is presented in cycle 32, done=1 in cycle 33, and the FSM is back in IDLE in cycle 34.
- Latency: one result per 2 cycles at full throughput. Each cycle of res_ready low adds one cycle.
- The ALU is combinational, so its outputs settle within the DRIVE cycle; there are no extra wait states.
- A start arriving in the same cycle as done is ignored. A start in cycle 34 (IDLE) is accepted.

## Test plan
- Reset mid-sweep: assert rst during OUT of opcode 7 -> all outputs are 0 before the next edge. Then start with a=25, b=25 -> the sweep restarts at res_opcode=0.
- Full sweep: a_in=0x8F, b_in=0x03, carry/borrow=0, res_ready=1 -> 16 results with res_opcode 0..15 in order. res_valid is high in cycles 2,4,…,32; done is high in cycle 33 only; busy is high in cycles 1–32.
- Backpressure: hold res_ready=0 for 5 cycles while opcode 3 is presented -> res_opcode=3 and res_y are stable, alu_opcode stays 3, and done moves to cycle 38.
- Start while busy: pulse start with a_in=0x11 in cycle 10 -> ignored; alu_a stays 0x8F and the sweep completes normally.
- Invalid opcodes: use an ALU model that flags opcodes 14 and 15 -> res_flags[4]=1 for exactly those two results, and invalid_count=2 after done.
- Zero flag: a=25, b=25 -> the opcode-1 (subtract) result has res_y=0 and res_flags[2]=1.
